writeback_stage: RTL and testbench

//   Final pipeline stage: drives the register-file write port (we/wa/wd) that the decode/read stage's regfile consumes.

---
 rtl/writeback_stage_pkg.sv | 18 +
 rtl/writeback_stage_load_align.sv | 43 ++++
 rtl/writeback_stage.sv | 127 ++++++++++++
 tb/tb_writeback_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package writeback_stage_pkg;

    // RISC-V load funct3 encodings; any other value is treated as a full word.
    localparam logic [2:0] FNC_LB  = 3'd0;
    localparam logic [2:0] FNC_LH  = 3'd1;
    localparam logic [2:0] FNC_LW  = 3'd2;
    localparam logic [2:0] FNC_LBU = 3'd4;
    localparam logic [2:0] FNC_LHU = 3'd5;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load aligner: picks the byte/halfword addressed inside a response word and extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_word (word-aligned memory data), i_addr (byte offset), i_funct3 (width/sign),
//        o_data (aligned, sign/zero-extended result).
module writeback_stage_load_align
    import writeback_stage_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Misaligned halfwords never trap: addr[0] is simply ignored.
    assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            FNC_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            FNC_LBU: o_data = {24'd0, w_byte};
            FNC_LH:  o_data = {{16{w_half[15]}}, w_half};
            FNC_LHU: o_data = {16'd0, w_half};
            FNC_LW:  o_data = i_word;
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: drives the regfile write port from ALU result, PC+4 or aligned load data.
// Latency: non-load 1 cycle after accept; load 1 cycle after the dmem_valid edge.
// Backpressure: stall_out is high for the whole load wait; the completion edge accepts nothing.
// Ports: clk/rst (sync, active-high); ex_* incoming instruction fields gated by bubble;
//        dmem_rdata/dmem_valid load response; we/wa/wd regfile write; stall_out upstream hold;
//        cycle_cnt/instret CSR counters; tohost CSR shadow (present only with WB_CSR_TOHOST_EN).
// Optional feature macro: WB_CSR_TOHOST_EN.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_TOHOST = 32'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bubble,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_we,
    input  logic            ex_mem_rr,
    input  logic            ex_is_jump,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_csr_write,
    input  logic [XLEN-1:0] ex_csr_data,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_valid,
    output logic            we,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd,
    output logic            stall_out,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret
`ifdef WB_CSR_TOHOST_EN
    ,
    output logic [XLEN-1:0] tohost
`endif
);

    wb_state_t       r_state;
    logic [4:0]      r_ld_rd;
    logic [1:0]      r_ld_addr;
    logic [2:0]      r_ld_funct3;
    logic            r_ld_we;

    logic [XLEN-1:0] w_pc_plus4;
    logic [31:0]     w_ld_data;

    assign w_pc_plus4 = ex_pc + XLEN'(4);

    writeback_stage_load_align u_align (
        .i_word   (dmem_rdata),
        .i_addr   (r_ld_addr),
        .i_funct3 (r_ld_funct3),
        .o_data   (w_ld_data)
    );

`ifndef WB_CSR_TOHOST_EN
    // Without the tohost shadow the CSR payload has nowhere to go.
    logic w_unused;
    assign w_unused = ^{ex_csr_data, RESET_TOHOST};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WB_IDLE;
            r_ld_rd     <= 5'd0;
            r_ld_addr   <= 2'd0;
            r_ld_funct3 <= 3'd0;
            r_ld_we     <= 1'b0;
            we          <= 1'b0;
            wa          <= 5'd0;
            wd          <= '0;
            stall_out   <= 1'b0;
            cycle_cnt   <= '0;
            instret     <= '0;
`ifdef WB_CSR_TOHOST_EN
            tohost      <= RESET_TOHOST;
`endif
        end else begin
            cycle_cnt <= cycle_cnt + XLEN'(1);
            // we is a one-cycle pulse; only a retirement raises it.
            we <= 1'b0;
            case (r_state)
                WB_IDLE: begin
                    if (!bubble) begin
                        if (ex_mem_rr) begin
                            r_state     <= WB_WAIT_LOAD;
                            stall_out   <= 1'b1;
                            r_ld_rd     <= ex_rd;
                            r_ld_addr   <= ex_alu_out[1:0];
                            r_ld_funct3 <= ex_funct3;
                            r_ld_we     <= ex_reg_we && (ex_rd != 5'd0);
                        end else begin
                            // CSR writes retire without touching the regfile.
                            we      <= ex_reg_we && (ex_rd != 5'd0) && !ex_csr_write;
                            wa      <= ex_rd;
                            wd      <= ex_is_jump ? w_pc_plus4 : ex_alu_out;
                            instret <= instret + XLEN'(1);
`ifdef WB_CSR_TOHOST_EN
                            if (ex_csr_write) begin
                                tohost <= ex_csr_data;
                            end
`endif
                        end
                    end
                end
                WB_WAIT_LOAD: begin
                    // Completion edge returns to IDLE without accepting a new slot.
                    if (dmem_valid) begin
                        r_state   <= WB_IDLE;
                        stall_out <= 1'b0;
                        we        <= r_ld_we;
                        wa        <= r_ld_rd;
                        wd        <= w_ld_data;
                        instret   <= instret + XLEN'(1);
                    end
                end
                default: begin
                    r_state   <= WB_IDLE;
                    stall_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        bubble;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_rr;
    logic        ex_is_jump;
    logic [2:0]  ex_funct3;
    logic        ex_csr_write;
    logic [31:0] ex_csr_data;
    logic [31:0] dmem_rdata;
    logic        dmem_valid;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall_out;
    logic [31:0] cycle_cnt;
    logic [31:0] instret;
`ifdef WB_CSR_TOHOST_EN
    logic [31:0] tohost;
    logic [31:0] m_tohost;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_cycle;
    logic [31:0] m_instret;

    writeback_stage dut (
        .clk          (clk),
        .rst          (rst),
        .bubble       (bubble),
        .ex_alu_out   (ex_alu_out),
        .ex_pc        (ex_pc),
        .ex_rd        (ex_rd),
        .ex_reg_we    (ex_reg_we),
        .ex_mem_rr    (ex_mem_rr),
        .ex_is_jump   (ex_is_jump),
        .ex_funct3    (ex_funct3),
        .ex_csr_write (ex_csr_write),
        .ex_csr_data  (ex_csr_data),
        .dmem_rdata   (dmem_rdata),
        .dmem_valid   (dmem_valid),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .stall_out    (stall_out),
        .cycle_cnt    (cycle_cnt),
        .instret      (instret)
`ifdef WB_CSR_TOHOST_EN
        ,
        .tohost       (tohost)
`endif
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1ns later. Cycle model follows reset.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) m_cycle = 32'd0;
        else     m_cycle = m_cycle + 32'd1;
    endtask

    // Reference load extraction using shift/mask arithmetic.
    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] a, logic [2:0] f);
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        sh_b = 32'd8 * {30'd0, a};
        sh_h = a[1] ? 32'd16 : 32'd0;
        b = (w >> sh_b) & 32'h0000_00FF;
        h = (w >> sh_h) & 32'h0000_FFFF;
        case (f)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic idle_inputs();
        bubble       = 1'b1;
        ex_alu_out   = $urandom;
        ex_pc        = $urandom;
        ex_rd        = 5'($urandom);
        ex_reg_we    = 1'($urandom);
        ex_mem_rr    = 1'($urandom);
        ex_is_jump   = 1'($urandom);
        ex_funct3    = 3'($urandom);
        ex_csr_write = 1'($urandom);
        ex_csr_data  = $urandom;
        dmem_rdata   = $urandom;
        dmem_valid   = 1'b0;
    endtask

    // Non-load instruction: accept, then check the one-cycle write and the pulse ending.
    task automatic run_alu(input logic [4:0] rd, input logic reg_we, input logic [31:0] alu,
                           input logic [31:0] pc, input logic jump, input logic csr,
                           input logic [31:0] csr_data);
        logic [31:0] exp_wd;
        logic        exp_we;
        bubble = 1'b0; ex_mem_rr = 1'b0;
        ex_rd = rd; ex_reg_we = reg_we; ex_alu_out = alu; ex_pc = pc;
        ex_is_jump = jump; ex_csr_write = csr; ex_csr_data = csr_data;
        dmem_valid = 1'($urandom);
        tick();
        idle_inputs();
        m_instret = m_instret + 32'd1;
        exp_we = reg_we && (rd != 5'd0) && !csr;
        exp_wd = jump ? pc + 32'd4 : alu;
        n_checks++;
        if (we !== exp_we) begin n_errors++; $display("FAIL alu_we rd=%0d got %b want %b", rd, we, exp_we); end
        if (!csr) begin
            n_checks++;
            if (wa !== rd) begin n_errors++; $display("FAIL alu_wa got %0d want %0d", wa, rd); end
            n_checks++;
            if (wd !== exp_wd) begin n_errors++; $display("FAIL alu_wd got %h want %h", wd, exp_wd); end
        end
        n_checks++;
        if (instret !== m_instret) begin n_errors++; $display("FAIL alu_instret got %0d want %0d", instret, m_instret); end
        n_checks++;
        if (stall_out !== 1'b0) begin n_errors++; $display("FAIL alu_stall got %b want 0", stall_out); end
`ifdef WB_CSR_TOHOST_EN
        if (csr) m_tohost = csr_data;
        n_checks++;
        if (tohost !== m_tohost) begin n_errors++; $display("FAIL tohost got %h want %h", tohost, m_tohost); end
`endif
        tick();
        n_checks++;
        if (we !== 1'b0) begin n_errors++; $display("FAIL we_pulse got %b want 0", we); end
    endtask

    // Load: accept, hold for 'waits' cycles with junk upstream, then complete.
    task automatic run_load(input logic [4:0] rd, input logic reg_we, input logic [31:0] addr,
                            input logic [2:0] f3, input logic [31:0] rdata, input int waits);
        logic [31:0] exp_wd;
        bubble = 1'b0; ex_mem_rr = 1'b1; ex_csr_write = 1'b0;
        ex_rd = rd; ex_reg_we = reg_we; ex_alu_out = addr; ex_funct3 = f3;
        dmem_valid = 1'b1;   // ignored while idle
        dmem_rdata = $urandom;
        tick();
        n_checks++;
        if (stall_out !== 1'b1 || we !== 1'b0) begin
            n_errors++; $display("FAIL load_accept stall=%b we=%b want stall=1 we=0", stall_out, we);
        end
        for (int i = 0; i < waits; i++) begin
            idle_inputs();
            bubble = 1'($urandom);   // upstream slot must be ignored while waiting
            tick();
            n_checks++;
            if (stall_out !== 1'b1 || we !== 1'b0 || instret !== m_instret) begin
                n_errors++;
                $display("FAIL load_wait stall=%b we=%b instret=%0d want 1 0 %0d", stall_out, we, instret, m_instret);
            end
        end
        idle_inputs();
        dmem_valid = 1'b1;
        dmem_rdata = rdata;
        tick();
        idle_inputs();
        m_instret = m_instret + 32'd1;
        exp_wd = ref_load(rdata, addr[1:0], f3);
        n_checks++;
        if (we !== (reg_we && rd != 5'd0)) begin n_errors++; $display("FAIL load_we got %b", we); end
        n_checks++;
        if (wa !== rd) begin n_errors++; $display("FAIL load_wa got %0d want %0d", wa, rd); end
        n_checks++;
        if (wd !== exp_wd) begin
            n_errors++; $display("FAIL load_wd f3=%0d a=%0d got %h want %h", f3, addr[1:0], wd, exp_wd);
        end
        n_checks++;
        if (stall_out !== 1'b0 || instret !== m_instret) begin
            n_errors++; $display("FAIL load_done stall=%b instret=%0d want 0 %0d", stall_out, instret, m_instret);
        end
        tick();
        n_checks++;
        if (we !== 1'b0) begin n_errors++; $display("FAIL load_pulse got %b want 0", we); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        m_instret = 32'd0;
        n_checks++;
        if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0 || stall_out !== 1'b0) begin
            n_errors++; $display("FAIL reset_port we=%b wa=%0d wd=%h stall=%b want all 0", we, wa, wd, stall_out);
        end
        n_checks++;
        if (cycle_cnt !== 32'd0 || instret !== 32'd0) begin
            n_errors++; $display("FAIL reset_cnt cycle=%0d instret=%0d want 0 0", cycle_cnt, instret);
        end
`ifdef WB_CSR_TOHOST_EN
        m_tohost = 32'd0;
        n_checks++;
        if (tohost !== 32'd0) begin n_errors++; $display("FAIL reset_tohost got %h want 0", tohost); end
`endif
        rst = 1'b0;
        tick();
        n_checks++;
        if (cycle_cnt !== m_cycle) begin n_errors++; $display("FAIL cycle_start got %0d want %0d", cycle_cnt, m_cycle); end
    endtask

    task automatic test_alu();
        run_alu(5'd5, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 1'b0, 1'b0, 32'd0);
        n_checks++;
        if (instret !== 32'd1) begin n_errors++; $display("FAIL first_instret got %0d want 1", instret); end
        run_alu(5'd9, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_jump();
        run_alu(5'd1, 1'b1, 32'h5555_5555, 32'h0000_1000, 1'b1, 1'b0, 32'd0);
        run_alu(5'd1, 1'b1, 32'h5555_5555, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_load();
        run_load(5'd7,  1'b1, 32'h0000_2003, 3'd0, 32'h80FF_0000, 3);
        run_load(5'd8,  1'b1, 32'h0000_2002, 3'd5, 32'h80FF_0000, 1);
        run_load(5'd10, 1'b1, 32'h0000_2001, 3'd1, 32'h1234_F678, 0);
        run_load(5'd11, 1'b1, 32'h0000_2003, 3'd7, 32'hCAFE_BABE, 2);
    endtask

    task automatic test_x0();
        run_alu(5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'd0);
        run_load(5'd0, 1'b1, 32'h0, 3'd2, 32'hA5A5_A5A5, 1);
    endtask

    task automatic test_reset_mid_load();
        bubble = 1'b0; ex_mem_rr = 1'b1; ex_rd = 5'd12; ex_reg_we = 1'b1;
        ex_alu_out = 32'h0; ex_funct3 = 3'd2; ex_csr_write = 1'b0;
        tick();
        idle_inputs();
        rst = 1'b1;
        dmem_valid = 1'b1;
        tick();
        m_instret = 32'd0;
        n_checks++;
        if (stall_out !== 1'b0 || we !== 1'b0 || instret !== 32'd0 || cycle_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_mid_load stall=%b we=%b instret=%0d cycle=%0d want 0 0 0 0", stall_out, we, instret, cycle_cnt);
        end
`ifdef WB_CSR_TOHOST_EN
        m_tohost = 32'd0;
`endif
        rst = 1'b0;
        dmem_valid = 1'b1;
        tick();
        n_checks++;
        if (stall_out !== 1'b0 || we !== 1'b0 || instret !== 32'd0) begin
            n_errors++; $display("FAIL rst_drop stall=%b we=%b instret=%0d want 0 0 0", stall_out, we, instret);
        end
        dmem_valid = 1'b0;
    endtask

    task automatic test_bubble();
        logic [31:0] c0;
        logic        any_we;
        idle_inputs();
        c0 = cycle_cnt;
        any_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            tick();
            any_we = any_we | we;
        end
        n_checks++;
        if (any_we !== 1'b0) begin n_errors++; $display("FAIL bubble_we got %b want 0", any_we); end
        n_checks++;
        if (instret !== m_instret) begin n_errors++; $display("FAIL bubble_instret got %0d want %0d", instret, m_instret); end
        n_checks++;
        if (cycle_cnt !== c0 + 32'd10) begin
            n_errors++; $display("FAIL bubble_cycle got %0d want %0d", cycle_cnt, c0 + 32'd10);
        end
        run_alu(5'd3, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0001);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_load(5'($urandom), 1'($urandom), $urandom, 3'($urandom), $urandom,
                         int'($urandom_range(0, 3)));
            end else begin
                run_alu(5'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
                        ($urandom_range(0, 7) == 0), $urandom);
            end
        end
        n_checks++;
        if (cycle_cnt !== m_cycle) begin n_errors++; $display("FAIL cycle_final got %0d want %0d", cycle_cnt, m_cycle); end
    endtask

    initial begin
        m_cycle = 32'd0;
        m_instret = 32'd0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alu();
        test_jump();
        test_load();
        test_x0();
        test_bubble();
        test_random();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
